// File: rtl/joy_db15_pkg.sv
// Shared definitions for the DB15 SNAC joystick link (transmitter and receiver).
package joy_db15_pkg;

    localparam int unsigned PLAYER_BITS = 12;

    localparam int unsigned BTN_R      = 0;
    localparam int unsigned BTN_L      = 1;
    localparam int unsigned BTN_D      = 2;
    localparam int unsigned BTN_U      = 3;
    localparam int unsigned BTN_A      = 4;
    localparam int unsigned BTN_B      = 5;
    localparam int unsigned BTN_C      = 6;
    localparam int unsigned BTN_X      = 7;
    localparam int unsigned BTN_Y      = 8;
    localparam int unsigned BTN_Z      = 9;
    localparam int unsigned BTN_SELECT = 10;
    localparam int unsigned BTN_START  = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } db15_state_e;

endpackage

// File: rtl/joy_db15_sync.sv
// Two-flop synchronizer with rise/fall pulses for one host pin.
// Optional JOY_DB15_TX_GLITCH_FILTER_EN adds a 3-sample agreement filter.
module joy_db15_sync (
    input  logic clk_sys,
    input  logic RESET_N,
    input  logic pin,
    output logic level_c,
    output logic rise_c,
    output logic fall_c
);

    logic [1:0] sync_q;
    logic       prev_q;

`ifdef JOY_DB15_TX_GLITCH_FILTER_EN
    logic [1:0] win_q;
    logic [2:0] samples;

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            win_q <= 2'b11;
        end else begin
            win_q <= {win_q[0], sync_q[1]};
        end
    end

    assign samples = {win_q, sync_q[1]};

    // Level only moves once all three samples agree; otherwise hold.
    always_comb begin
        level_c = prev_q;
        if (samples == 3'b111) begin
            level_c = 1'b1;
        end else if (samples == 3'b000) begin
            level_c = 1'b0;
        end
    end
`else
    assign level_c = sync_q[1];
`endif

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], pin};
            prev_q <= level_c;
        end
    end

    assign rise_c = level_c & ~prev_q;
    assign fall_c = ~level_c & prev_q;

endmodule

// File: rtl/joy_db15_tx.sv
// Device-side DB15 SNAC responder: latches two player words on JOY_LOAD and
// shifts them out on JOY_CLK. Optional macro: JOY_DB15_TX_GLITCH_FILTER_EN.
module joy_db15_tx
    import joy_db15_pkg::*;
#(
    parameter int unsigned FRAME_BITS   = 24,
    parameter int unsigned IDLE_TIMEOUT = 1048576,
    parameter int unsigned CNT_W        = 5
) (
    input  logic                   clk_sys,
    input  logic                   RESET_N,
    input  logic [PLAYER_BITS-1:0] joy1_in,
    input  logic [PLAYER_BITS-1:0] joy2_in,
    input  logic                   JOY_CLK,
    input  logic                   JOY_LOAD,
    output logic                   JOY_DATA,
    output logic                   frame_strobe,
    output logic [CNT_W-1:0]       bit_index,
    output logic                   link_active
);

    localparam int unsigned WD_W = $clog2(IDLE_TIMEOUT + 1);

    logic clk_level, clk_rise, clk_fall;
    logic load_level, load_rise, load_fall;
    logic clk_unused;

    joy_db15_sync u_sync_clk (
        .clk_sys (clk_sys),
        .RESET_N (RESET_N),
        .pin     (JOY_CLK),
        .level_c (clk_level),
        .rise_c  (clk_rise),
        .fall_c  (clk_fall)
    );

    joy_db15_sync u_sync_load (
        .clk_sys (clk_sys),
        .RESET_N (RESET_N),
        .pin     (JOY_LOAD),
        .level_c (load_level),
        .rise_c  (load_rise),
        .fall_c  (load_fall)
    );

    assign clk_unused = clk_level | clk_fall;

    logic [FRAME_BITS-1:0] frame;
    assign frame = FRAME_BITS'({joy2_in, joy1_in});

    db15_state_e           state_q, state_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]      idx_q, idx_d;
    logic                  data_q, data_d;
    logic                  strobe_q, strobe_d;

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= IDLE;
            shreg_q  <= '1;
            idx_q    <= '0;
            data_q   <= 1'b1;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
        end
    end

    // Load level overrides everything, so a coincident clock edge is dropped.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        idx_d    = idx_q;
        data_d   = data_q;
        strobe_d = 1'b0;
        if (!load_level) begin
            state_d = LOAD;
            shreg_d = ~frame;
            idx_d   = '0;
            data_d  = ~frame[0];
        end else begin
            unique case (state_q)
                IDLE: begin
                    data_d = shreg_q[0];
                end
                LOAD: begin
                    if (load_rise) begin
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    if (clk_rise) begin
                        shreg_d = {1'b1, shreg_q[FRAME_BITS-1:1]};
                        idx_d   = idx_q + CNT_W'(1);
                        data_d  = shreg_q[1];
                        if (idx_q == CNT_W'(FRAME_BITS - 1)) begin
                            state_d  = DONE;
                            strobe_d = 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Register is fully drained to ones here, so the line idles high.
                    data_d = shreg_q[0];
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    logic [WD_W-1:0] wd_q;
    logic            link_q;

    // Watchdog: restarted by each load fall, saturates at the timeout.
    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            wd_q   <= '0;
            link_q <= 1'b0;
        end else if (load_fall) begin
            wd_q   <= '0;
            link_q <= 1'b1;
        end else if (wd_q != WD_W'(IDLE_TIMEOUT)) begin
            wd_q <= wd_q + WD_W'(1);
            if (wd_q == WD_W'(IDLE_TIMEOUT - 1)) begin
                link_q <= 1'b0;
            end
        end
    end

    assign JOY_DATA     = data_q;
    assign frame_strobe = strobe_q;
    assign bit_index    = idx_q;
    assign link_active  = link_q;

endmodule

// File: tb/tb_joy_db15_tx.sv
// Directed self-checking bench for joy_db15_tx acting as a host would.
module tb_joy_db15_tx;

    localparam int unsigned TIMEOUT = 1000;
`ifdef JOY_DB15_TX_GLITCH_FILTER_EN
    localparam int unsigned LAT = 5;
`else
    localparam int unsigned LAT = 3;
`endif

    logic        clk_sys = 1'b0;
    logic        RESET_N;
    logic [11:0] joy1_in;
    logic [11:0] joy2_in;
    logic        JOY_CLK;
    logic        JOY_LOAD;
    logic        JOY_DATA;
    logic        frame_strobe;
    logic [4:0]  bit_index;
    logic        link_active;

    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;
    int link_fall_cnt = 0;
    logic link_prev = 1'b0;

    joy_db15_tx #(.FRAME_BITS(24), .IDLE_TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk_sys      (clk_sys),
        .RESET_N      (RESET_N),
        .joy1_in      (joy1_in),
        .joy2_in      (joy2_in),
        .JOY_CLK      (JOY_CLK),
        .JOY_LOAD     (JOY_LOAD),
        .JOY_DATA     (JOY_DATA),
        .frame_strobe (frame_strobe),
        .bit_index    (bit_index),
        .link_active  (link_active)
    );

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) begin
        if (frame_strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;
        if (link_prev === 1'b1 && link_active === 1'b0) link_fall_cnt <= link_fall_cnt + 1;
        link_prev <= link_active;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic host_load();
        JOY_LOAD = 1'b0;
        tick(8);
        JOY_LOAD = 1'b1;
        tick(8);
    endtask

    task automatic host_clock();
        JOY_CLK = 1'b1;
        tick(8);
        JOY_CLK = 1'b0;
        tick(8);
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        JOY_CLK = 1'b0;
        JOY_LOAD = 1'b1;
        joy1_in = 12'h000;
        joy2_in = 12'h000;
        tick(3);
        RESET_N = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            checks++;
            if (JOY_DATA !== 1'b1) begin errors++; $display("FAIL reset_data cyc %0d got %b exp 1", i, JOY_DATA); end
            checks++;
            if (link_active !== 1'b0) begin errors++; $display("FAIL reset_link cyc %0d got %b exp 0", i, link_active); end
            checks++;
            if (bit_index !== 5'd0) begin errors++; $display("FAIL reset_idx cyc %0d got %0d exp 0", i, bit_index); end
            checks++;
            if (frame_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe cyc %0d got %b exp 0", i, frame_strobe); end
        end
    endtask

    task automatic test_frame();
        logic [23:0] exp_stream;
        logic        exp_bit;
        int          s0;
        exp_stream = 24'h7FFFEE;
        joy1_in = 12'h011;
        joy2_in = 12'h800;
        s0 = strobe_cnt;
        host_load();
        checks++;
        if (bit_index !== 5'd0) begin errors++; $display("FAIL frame_idx0 got %0d exp 0", bit_index); end
        checks++;
        if (JOY_DATA !== exp_stream[0]) begin errors++; $display("FAIL frame_bit0 got %b exp %b", JOY_DATA, exp_stream[0]); end
        for (int k = 1; k <= 24; k++) begin
            if (k == 3) joy1_in = 12'h000;
            host_clock();
            exp_bit = (k < 24) ? exp_stream[k] : 1'b1;
            checks++;
            if (JOY_DATA !== exp_bit) begin errors++; $display("FAIL frame_bit k %0d got %b exp %b", k, JOY_DATA, exp_bit); end
            checks++;
            if (bit_index !== 5'(k)) begin errors++; $display("FAIL frame_idx k %0d got %0d exp %0d", k, bit_index, k); end
            checks++;
            if (strobe_cnt !== s0 + ((k == 24) ? 1 : 0)) begin
                errors++; $display("FAIL frame_strobe k %0d got %0d exp %0d", k, strobe_cnt - s0, (k == 24) ? 1 : 0);
            end
        end
    endtask

    task automatic test_abort();
        int s0;
        joy1_in = 12'h0A5;
        joy2_in = 12'h3C3;
        s0 = strobe_cnt;
        host_load();
        for (int k = 0; k < 10; k++) host_clock();
        checks++;
        if (bit_index !== 5'd10) begin errors++; $display("FAIL abort_pre_idx got %0d exp 10", bit_index); end
        JOY_LOAD = 1'b0;
        JOY_CLK = 1'b1;
        tick(8);
        checks++;
        if (bit_index !== 5'd0) begin errors++; $display("FAIL abort_idx got %0d exp 0", bit_index); end
        checks++;
        if (JOY_DATA !== 1'b0) begin errors++; $display("FAIL abort_data got %b exp 0", JOY_DATA); end
        JOY_LOAD = 1'b1;
        JOY_CLK = 1'b0;
        tick(8);
        checks++;
        if (JOY_DATA !== 1'b0 || bit_index !== 5'd0) begin
            errors++; $display("FAIL abort_release got data %b idx %0d exp data 0 idx 0", JOY_DATA, bit_index);
        end
        host_clock();
        checks++;
        if (JOY_DATA !== 1'b1 || bit_index !== 5'd1) begin
            errors++; $display("FAIL abort_next got data %b idx %0d exp data 1 idx 1", JOY_DATA, bit_index);
        end
        checks++;
        if (strobe_cnt !== s0) begin errors++; $display("FAIL abort_strobe got %0d exp 0", strobe_cnt - s0); end
    endtask

    task automatic test_saturate();
        int s0;
        joy1_in = 12'h000;
        joy2_in = 12'h000;
        host_load();
        s0 = strobe_cnt;
        for (int k = 1; k <= 30; k++) begin
            host_clock();
            checks++;
            if (JOY_DATA !== 1'b1) begin errors++; $display("FAIL sat_data k %0d got %b exp 1", k, JOY_DATA); end
            checks++;
            if (bit_index !== 5'((k < 24) ? k : 24)) begin
                errors++; $display("FAIL sat_idx k %0d got %0d exp %0d", k, bit_index, (k < 24) ? k : 24);
            end
        end
        checks++;
        if (strobe_cnt !== s0 + 1) begin errors++; $display("FAIL sat_strobe got %0d exp 1", strobe_cnt - s0); end
    endtask

    task automatic test_watchdog();
        int f0;
        f0 = link_fall_cnt;
        JOY_LOAD = 1'b0;
        tick(8);
        JOY_LOAD = 1'b1;
        tick(TIMEOUT + LAT - 1 - 8);
        checks++;
        if (link_active !== 1'b1) begin errors++; $display("FAIL wd_before got %b exp 1", link_active); end
        tick(1);
        checks++;
        if (link_active !== 1'b0) begin errors++; $display("FAIL wd_drop got %b exp 0", link_active); end
        tick(50);
        checks++;
        if (link_fall_cnt !== f0 + 1) begin errors++; $display("FAIL wd_fall_count got %0d exp 1", link_fall_cnt - f0); end
        JOY_LOAD = 1'b0;
        tick(LAT - 1);
        checks++;
        if (link_active !== 1'b0) begin errors++; $display("FAIL wd_relink_early got %b exp 0", link_active); end
        tick(1);
        checks++;
        if (link_active !== 1'b1) begin errors++; $display("FAIL wd_relink got %b exp 1", link_active); end
        tick(8);
        JOY_LOAD = 1'b1;
        tick(8);
    endtask

    task automatic test_async_reset();
        joy1_in = 12'h0A5;
        host_load();
        for (int k = 0; k < 5; k++) host_clock();
        @(posedge clk_sys);
        #3;
        RESET_N = 1'b0;
        #1;
        checks++;
        if (JOY_DATA !== 1'b1 || bit_index !== 5'd0 || link_active !== 1'b0 || frame_strobe !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got data %b idx %0d link %b strobe %b exp 1 0 0 0", JOY_DATA, bit_index, link_active, frame_strobe);
        end
        tick(2);
        RESET_N = 1'b1;
        tick(4);
        host_load();
        checks++;
        if (JOY_DATA !== 1'b0 || bit_index !== 5'd0 || link_active !== 1'b1) begin
            errors++; $display("FAIL async_recover got data %b idx %0d link %b exp 0 0 1", JOY_DATA, bit_index, link_active);
        end
    endtask

`ifdef JOY_DB15_TX_GLITCH_FILTER_EN
    task automatic test_glitch();
        joy1_in = 12'h001;
        joy2_in = 12'h000;
        host_load();
        JOY_CLK = 1'b1;
        tick(2);
        JOY_CLK = 1'b0;
        tick(10);
        checks++;
        if (bit_index !== 5'd0 || JOY_DATA !== 1'b0) begin
            errors++; $display("FAIL glitch_short got idx %0d data %b exp 0 0", bit_index, JOY_DATA);
        end
        JOY_CLK = 1'b1;
        tick(4);
        checks++;
        if (JOY_DATA !== 1'b0) begin errors++; $display("FAIL glitch_early got %b exp 0", JOY_DATA); end
        tick(1);
        checks++;
        if (JOY_DATA !== 1'b1 || bit_index !== 5'd1) begin
            errors++; $display("FAIL glitch_shift got data %b idx %0d exp 1 1", JOY_DATA, bit_index);
        end
        tick(1);
        JOY_CLK = 1'b0;
        tick(8);
    endtask
`endif

    initial begin
        test_reset();
        test_frame();
        test_abort();
        test_saturate();
        test_watchdog();
        test_async_reset();
`ifdef JOY_DB15_TX_GLITCH_FILTER_EN
        test_glitch();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/joy_db15_tx.md
Name: joy_db15_tx

Overview:
Device-side responder for the serial DB15 SNAC joystick link. It emulates the adapter's parallel-in/serial-out shift chain. It latches two 12-bit player button words when the host pulses JOY_LOAD, then presents one bit per host JOY_CLK rising edge on JOY_DATA. It is used in loopback benches and in the USER-port test harness, paired against the existing DB15 receiver.

Parameters:
- FRAME_BITS, 24: bits per frame (two players × 12).
- IDLE_TIMEOUT, 1048576: clk_sys cycles with no JOY_LOAD edge before link_active drops.
- CNT_W, 5: width of bit_index; must satisfy 2^CNT_W > FRAME_BITS.

Ports:
- clk_sys, in, 1: system clock (48 MHz).
- RESET_N, in, 1: asynchronous active-low reset.
- joy1_in, in, 12: player 1 buttons, active-high pressed. Bits [0]R [1]L [2]D [3]U [4]A [5]B [6]C [7]X [8]Y [9]Z [10]Select [11]Start.
- joy2_in, in, 12: player 2 buttons, same layout.
- JOY_CLK, in, 1: host shift clock; asynchronous to clk_sys.
- JOY_LOAD, in, 1: host load strobe, active-low; asynchronous.
- JOY_DATA, out, 1: serial data, active-low (0 = pressed).
- frame_strobe, out, 1: one-cycle pulse when the last frame bit has been shifted.
- bit_index, out, CNT_W: index of the bit currently on JOY_DATA.
- link_active, out, 1: host has issued a load within IDLE_TIMEOUT cycles.

Behaviour:
- Reset values:
  - JOY_DATA=1, frame_strobe=0, bit_index=0, link_active=0.
  - Shift register all 1s; FSM in IDLE.
  - Synchronizer flops preset to 1.
- Input synchronisation:
  - JOY_CLK and JOY_LOAD each pass through a 2-flop synchronizer plus an edge-detect register.
  - Pin-to-action latency: 3 clk_sys cycles.
  - Host must hold each pin level for at least 4 clk_sys cycles.
- Frame word:
  - frame[k] = joy1_in[k] for k<12; frame[k] = joy2_in[k-12] for 12≤k<24.
  - Stored inverted in the shift register.
- FSM states: IDLE, LOAD, SHIFT, DONE.
  - Any state → LOAD while synced JOY_LOAD=0. Load has priority over a simultaneous JOY_CLK rise.
  - In LOAD, the register reloads every cycle (transparent); bit_index=0.
  - LOAD → SHIFT on synced JOY_LOAD rising.
  - In SHIFT, each synced JOY_CLK rising edge does three things:
    - shift right, filling 1 at the top;
    - increment bit_index;
    - JOY_DATA = register bit 0.
  - The edge that brings bit_index to FRAME_BITS goes SHIFT → DONE and asserts frame_strobe for 1 cycle.
  - In DONE, further JOY_CLK edges keep JOY_DATA=1. bit_index saturates at FRAME_BITS; no wrap.
  - IDLE is entered only from reset; JOY_DATA=1 there.
- JOY_DATA is registered and equals ~frame[bit_index] while bit_index<FRAME_BITS.
- Input sampling: joy inputs are sampled only during LOAD. Changes during SHIFT do not affect the current frame.
- Watchdog:
  - Counter cleared on every synced JOY_LOAD falling edge, which also sets link_active=1.
  - At IDLE_TIMEOUT the counter saturates and link_active=0.
- Boundary cases:
  - Load mid-frame aborts the frame immediately; no frame_strobe.
  - RESET_N low mid-frame forces reset values asynchronously.
  - The output recovers on the first load after release.

Optional Feature:
JOY_DB15_TX_GLITCH_FILTER_EN.
- Defined: after the synchronizer, JOY_CLK and JOY_LOAD pass through a 3-sample shift window. The filtered level changes only when all 3 samples agree. Latency becomes 5 cycles; minimum pin level becomes 6 cycles.
- Undefined: raw synchronized levels are used; latency is 3.

Decomposition:
- Package joy_db15_pkg holds:
  - button bit-index localparams (BTN_R … BTN_START);
  - PLAYER_BITS=12;
  - the FSM state enum typedef (IDLE/LOAD/SHIFT/DONE).
- The receiver shares the same package.
- One sub-module, joy_db15_sync: synchronizer + optional glitch filter + rise/fall edge pulses. It is instantiated twice.

Test Plan:
- Reset release: JOY_DATA=1, link_active=0, bit_index=0 for 100 cycles with no host activity.
- joy1_in=12'h011 (R+A), joy2_in=12'h800 (Start); load, then 24 clocks → serial stream 0,1,1,1,0,1×7, then 1×11,0. frame_strobe pulses once after clock 24.
- Load asserted coincident with a JOY_CLK rise at bit 10 → bit_index=0, JOY_DATA=~joy1_in[0]; no frame_strobe.
- 30 clocks after load with all buttons released → bits 24–29 read 1; bit_index holds at 24.
- No load for IDLE_TIMEOUT+1 cycles after an active link → link_active falls exactly once; the next load sets it within 3 cycles.
- With JOY_DB15_TX_GLITCH_FILTER_EN: a 2-cycle JOY_CLK pulse → no shift. A 6-cycle pulse → one shift, JOY_DATA changes 5 cycles after the rising edge.
